// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Holds the FSM encoding, the op encoding and helpers that derive the step
// count N = WIDTH/K and the step-counter width from the top's parameters.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default configuration: 32-bit operands, one bit per step.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_K     = 1;

  function automatic int calc_steps(input int width, input int k);
    return width / k;
  endfunction

  // A single-step configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N     = calc_steps(DEF_WIDTH, DEF_K);
  localparam int DEF_CNT_W = calc_cnt_w(DEF_N);

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// K-bit ripple chain of F_ADD full-adder cells.
// Ports: a, b (K bits), cin -> sum (K bits), cout (chain carry-out),
//        c_top_in (carry into the top bit of the chain, used for overflow).
// F_ADD is the 1-bit full-adder library cell; a behavioural model of it is
// kept here so the block elaborates stand-alone.
module F_ADD (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);
  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));
endmodule

module digit_adder #(
  parameter int K = 1
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         c_top_in
);
  logic [K:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < K; i++) begin : g_fa
    F_ADD u_fa (
      .A (a[i]),
      .B (b[i]),
      .CI(c[i]),
      .S (sum[i]),
      .CO(c[i+1])
    );
  end

  assign cout     = c[K];
  // For K=1 this is simply cin, i.e. the carry held from the previous step.
  assign c_top_in = c[K-1];
endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor. Processes BITS_PER_CYCLE bits per clock over
// N = WIDTH/BITS_PER_CYCLE steps; returns result plus carry/overflow/zero.
// Ports:
//   I_CLK, I_RST          clock, synchronous active-high reset
//   I_VALID/O_READY       request handshake (I_OP_SUB, I_A, I_B)
//   O_VALID/I_READY       result handshake (O_RESULT, O_CARRY, O_OVF, O_ZERO)
// One operation in flight; O_READY only in IDLE, O_VALID only in DONE.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_K
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_VALID,
  output logic             O_READY,
  input  logic             I_OP_SUB,
  input  logic [WIDTH-1:0] I_A,
  input  logic [WIDTH-1:0] I_B,
  output logic             O_VALID,
  input  logic             I_READY,
  output logic [WIDTH-1:0] O_RESULT,
  output logic             O_CARRY,
  output logic             O_OVF,
  output logic             O_ZERO
);
  localparam int K     = BITS_PER_CYCLE;
  localparam int N     = calc_steps(WIDTH, K);
  localparam int CNT_W = calc_cnt_w(N);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [K-1:0]     d_sum;
  logic             d_cout, d_ctop;

  digit_adder #(.K(K)) u_digit (
    .a       (a_sh[K-1:0]),
    .b       (b_sh[K-1:0]),
    .cin     (carry_r),
    .sum     (d_sum),
    .cout    (d_cout),
    .c_top_in(d_ctop)
  );

  assign last     = (cnt == CNT_W'(N - 1));
  assign O_RESULT = res_sh;

  // Sum digits enter at the MSB end; after N steps the LSB digit has reached
  // bit 0. A shift by K==WIDTH yields zero, so the K=WIDTH case needs no
  // special handling.
  always_comb begin
    res_nxt = res_sh >> K;
    res_nxt[WIDTH-1 -: K] = d_sum;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (I_VALID)  state_nxt = BUSY;
      BUSY:    if (last)     state_nxt = DONE;
      DONE:    if (I_READY)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state   <= IDLE;
      O_READY <= 1'b1;
      O_VALID <= 1'b0;
    end else begin
      state   <= state_nxt;
      O_READY <= (state_nxt == IDLE);
      O_VALID <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      O_CARRY <= 1'b0;
      O_OVF   <= 1'b0;
      O_ZERO  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (I_VALID) begin
          // Subtract as A + ~B + 1: invert B and seed the carry with 1.
          a_sh    <= I_A;
          b_sh    <= I_B ^ {WIDTH{I_OP_SUB == OP_SUB}};
          carry_r <= (I_OP_SUB == OP_SUB);
          cnt     <= '0;
        end
        BUSY: begin
          res_sh  <= res_nxt;
          a_sh    <= a_sh >> K;
          b_sh    <= b_sh >> K;
          carry_r <= d_cout;
          cnt     <= cnt + 1'b1;
          if (last) begin
            O_CARRY <= d_cout;
            O_OVF   <= d_ctop ^ d_cout;
            O_ZERO  <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench: directed table on the K=1 instance, hand-written
// handshake/reset sequences, and random ops on K=4 and K=32 instances
// compared against a 33-bit arithmetic model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld  [3];
  logic        rdy  [3];
  logic        sub  [3];
  logic [31:0] a_in [3];
  logic [31:0] b_in [3];
  logic        ovld [3];
  logic        ird  [3];
  logic [31:0] res  [3];
  logic        c_o  [3];
  logic        v_o  [3];
  logic        z_o  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_k1 (
    .I_CLK(clk), .I_RST(rst), .I_VALID(vld[0]), .O_READY(rdy[0]),
    .I_OP_SUB(sub[0]), .I_A(a_in[0]), .I_B(b_in[0]), .O_VALID(ovld[0]),
    .I_READY(ird[0]), .O_RESULT(res[0]), .O_CARRY(c_o[0]), .O_OVF(v_o[0]),
    .O_ZERO(z_o[0]));

  serial_add_sub #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_k4 (
    .I_CLK(clk), .I_RST(rst), .I_VALID(vld[1]), .O_READY(rdy[1]),
    .I_OP_SUB(sub[1]), .I_A(a_in[1]), .I_B(b_in[1]), .O_VALID(ovld[1]),
    .I_READY(ird[1]), .O_RESULT(res[1]), .O_CARRY(c_o[1]), .O_OVF(v_o[1]),
    .O_ZERO(z_o[1]));

  serial_add_sub #(.WIDTH(32), .BITS_PER_CYCLE(32)) u_k32 (
    .I_CLK(clk), .I_RST(rst), .I_VALID(vld[2]), .O_READY(rdy[2]),
    .I_OP_SUB(sub[2]), .I_A(a_in[2]), .I_B(b_in[2]), .O_VALID(ovld[2]),
    .I_READY(ird[2]), .O_RESULT(res[2]), .O_CARRY(c_o[2]), .O_OVF(v_o[2]),
    .O_ZERO(z_o[2]));

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Golden model: plain 33-bit arithmetic, overflow from operand/result signs.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v,
                       output logic z);
    logic [32:0] full;
    logic [31:0] bb;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    r    = full[31:0];
    c    = full[32];
    v    = (a[31] == bb[31]) && (r[31] != a[31]);
    z    = (r == 32'd0);
  endtask

  task automatic wait_ready(input int d, input string nm);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (rdy[d] !== 1'b1) chk({nm, "_ready_timeout"}, 64'(rdy[d]), 64'd1);
  endtask

  // Issue one op, measure latency from the accept edge, check result, consume.
  task automatic run_op(input int d, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] e_r, input logic e_c, input logic e_v,
                        input logic e_z, input string nm);
    int lat = 0;
    wait_ready(d, nm);
    @(negedge clk);
    vld[d] = 1'b1; sub[d] = s; a_in[d] = a; b_in[d] = b;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    do begin
      @(posedge clk); #1; lat++;
    end while (ovld[d] !== 1'b1 && lat < 100);
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_res_cvz"}, {29'd0, res[d], c_o[d], v_o[d], z_o[d]},
        {29'd0, e_r, e_c, e_v, e_z});
    @(negedge clk); ird[d] = 1'b1;
    @(posedge clk); #1; ird[d] = 1'b0;
    chk({nm, "_consumed"}, {62'd0, ovld[d], rdy[d]}, 64'b01);
  endtask

  initial begin
    logic [31:0] r;
    logic        c, v, z;
    int          lat;

    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; sub[d] = 1'b0; a_in[d] = '0; b_in[d] = '0; ird[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_state_%0d", d),
          {28'd0, rdy[d], ovld[d], res[d], c_o[d], v_o[d], z_o[d]},
          {28'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst = 1'b0;

    // Directed table on K=1.
    for (int i = 0; i < 9; i++)
      run_op(0, vecs[i].sub, vecs[i].a, vecs[i].b, 32, vecs[i].res,
             vecs[i].c, vecs[i].v, vecs[i].z, $sformatf("vec%0d", i));

    // Backpressure + second request held during BUSY/DONE.
    @(negedge clk);
    vld[0] = 1'b1; sub[0] = 1'b0; a_in[0] = 32'd1; b_in[0] = 32'd2;
    @(posedge clk); #1;
    a_in[0] = 32'd10; b_in[0] = 32'd20;        // pending second request
    chk("busy_not_ready", 64'(rdy[0]), 64'd0);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (ovld[0] !== 1'b1 && lat < 100);
    chk("bp_latency", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++)
      chk($sformatf("bp_hold_%0d", i),
          {28'd0, rdy[0], ovld[0], res[0], c_o[0], v_o[0], z_o[0]},
          {28'd0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_stable_%0d", i),
          {28'd0, rdy[0], ovld[0], res[0], c_o[0], v_o[0], z_o[0]},
          {28'd0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk); ird[0] = 1'b1;
    @(posedge clk); #1; ird[0] = 1'b0;
    chk("bp_consumed", {62'd0, ovld[0], rdy[0]}, 64'b01);
    @(posedge clk); #1;                        // second request taken here
    vld[0] = 1'b0;
    chk("second_accepted", 64'(rdy[0]), 64'd0);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (ovld[0] !== 1'b1 && lat < 100);
    chk("second_latency", 64'(lat), 64'd32);
    chk("second_res", 64'(res[0]), 64'd30);
    @(negedge clk); ird[0] = 1'b1;
    @(posedge clk); #1; ird[0] = 1'b0;

    // Reset mid-BUSY aborts the op.
    wait_ready(0, "rst_mid");
    @(negedge clk);
    vld[0] = 1'b1; sub[0] = 1'b0; a_in[0] = 32'h0000_FFFF; b_in[0] = 32'h0000_FFFF;
    @(posedge clk); #1; vld[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_mid_state", {29'd0, rdy[0], ovld[0], res[0]}, {29'd0, 1'b1, 1'b0, 32'd0});
    lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ovld[0] === 1'b1) lat++;
    end
    chk("rst_mid_no_valid", 64'(lat), 64'd0);
    run_op(0, 1'b0, 32'd2, 32'd2, 32, 32'd4, 1'b0, 1'b0, 1'b0, "after_rst");

    // Random sweep on K=4 (N=8) and K=32 (N=1).
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        logic        s;
        logic [31:0] a, b;
        s = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
          0: a = 32'h7FFF_FFFF;
          1: b = a;
          2: a = 32'h8000_0000;
          3: b = 32'hFFFF_FFFF;
          default: ;
        endcase
        model(s, a, b, r, c, v, z);
        run_op(d, s, a, b, (d == 1) ? 8 : 1, r, c, v, z,
               $sformatf("rnd_k%0d_%0d", (d == 1) ? 4 : 32, i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
